// File: rtl/dcache_load_ctrl_if.sv
// Load-port bundle between the core, the tag-compare/SRAM stage and the miss handler.
// Signal suffixes are from the controller's point of view.
interface dcache_load_ctrl_if #(
   parameter int SET_ASSOC   = 8,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int LINE_WIDTH  = 128,
   parameter int DATA_WIDTH  = 64
) ();

   logic                              req_i;
   logic                              gnt_o;
   logic [INDEX_WIDTH-1:0]            index_i;
   logic                              tag_valid_i;
   logic [TAG_WIDTH-1:0]              tag_i;
   logic                              kill_i;
   logic                              rvalid_o;
   logic [DATA_WIDTH-1:0]             rdata_o;

   logic [SET_ASSOC-1:0]              sram_req_o;
   logic                              sram_gnt_i;
   logic [INDEX_WIDTH-1:0]            sram_addr_o;
   logic [TAG_WIDTH-1:0]              sram_tag_o;
   logic [SET_ASSOC-1:0]              hit_way_i;
   logic [SET_ASSOC*LINE_WIDTH-1:0]   line_i;

   logic                              miss_req_o;
   logic                              miss_gnt_i;
   logic [TAG_WIDTH+INDEX_WIDTH-1:0]  miss_addr_o;
   logic                              miss_valid_i;
   logic [DATA_WIDTH-1:0]             miss_rdata_i;

   // controller side
   modport slave (
      input  req_i, index_i, tag_valid_i, tag_i, kill_i,
      input  sram_gnt_i, hit_way_i, line_i,
      input  miss_gnt_i, miss_valid_i, miss_rdata_i,
      output gnt_o, rvalid_o, rdata_o,
      output sram_req_o, sram_addr_o, sram_tag_o,
      output miss_req_o, miss_addr_o
   );

   // core / cache-array / miss-handler side
   modport master (
      output req_i, index_i, tag_valid_i, tag_i, kill_i,
      output sram_gnt_i, hit_way_i, line_i,
      output miss_gnt_i, miss_valid_i, miss_rdata_i,
      input  gnt_o, rvalid_o, rdata_o,
      input  sram_req_o, sram_addr_o, sram_tag_o,
      input  miss_req_o, miss_addr_o
   );

endinterface

// File: rtl/dcache_load_ctrl.sv
// Single-port data-cache load controller: index-phase SRAM read, late tag,
// hit word return, and miss forwarding with refill-word return.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a load; request forwarded to the SRAM stage
// S_TAG       | tag phase of a granted load; hit/miss resolved this cycle
// S_REPLAY    | tag arrived late; re-issue the latched index
// S_MISS_REQ  | presenting {tag, index} to the miss handler
// S_MISS_WAIT | waiting for the refill word; a kill only suppresses rvalid
module dcache_load_ctrl #(
   parameter int SET_ASSOC   = 8,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int LINE_WIDTH  = 128,
   parameter int DATA_WIDTH  = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   dcache_load_ctrl_if.slave bus
);

   localparam int WAY_W  = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1;
   localparam int WORDS  = LINE_WIDTH / DATA_WIDTH;
   localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int OFF_LO = $clog2(DATA_WIDTH / 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TAG,
      S_REPLAY,
      S_MISS_REQ,
      S_MISS_WAIT
   } state_e;

   state_e                  state_q, state_d;
   logic [INDEX_WIDTH-1:0]  index_q, index_d;
   logic [TAG_WIDTH-1:0]    tag_q, tag_d;
   logic                    killed_q, killed_d;

   logic                              gnt;
   logic                              rvalid;
   logic [DATA_WIDTH-1:0]             rdata;
   logic [SET_ASSOC-1:0]              sram_req;
   logic [INDEX_WIDTH-1:0]            sram_addr;
   logic [TAG_WIDTH-1:0]              sram_tag;
   logic                              miss_req;
   logic [TAG_WIDTH+INDEX_WIDTH-1:0]  miss_addr;
   logic                              refill_live;

   logic [LINE_WIDTH-1:0]  way_line [SET_ASSOC];
   logic [LINE_WIDTH-1:0]  hit_line;
   logic [DATA_WIDTH-1:0]  line_word [WORDS];
   logic [DATA_WIDTH-1:0]  hit_word;
   logic [WAY_W-1:0]       hit_sel;

   for (genvar w = 0; w < SET_ASSOC; w++) begin : g_way
      assign way_line[w] = bus.line_i[w*LINE_WIDTH +: LINE_WIDTH];
   end

   // Descending scan so a multi-hit resolves to the lowest-numbered way.
   always_comb begin
      hit_sel = '0;
      for (int w = SET_ASSOC - 1; w >= 0; w--) begin
         if (bus.hit_way_i[w]) hit_sel = WAY_W'(w);
      end
   end

   assign hit_line = way_line[hit_sel];

   for (genvar k = 0; k < WORDS; k++) begin : g_word
      assign line_word[k] = hit_line[k*DATA_WIDTH +: DATA_WIDTH];
   end

   if (WORDS > 1) begin : g_wsel
      logic [WSEL_W-1:0] word_sel;
      assign word_sel = index_q[OFF_LO +: WSEL_W];
      assign hit_word = line_word[word_sel];
   end else begin : g_wsel_one
      assign hit_word = line_word[0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         index_q  <= '0;
         tag_q    <= '0;
         killed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         tag_q    <= tag_d;
         killed_q <= killed_d;
      end
   end

   assign refill_live = !(killed_q || bus.kill_i);

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      tag_d     = tag_q;
      killed_d  = killed_q;
      gnt       = 1'b0;
      rvalid    = 1'b0;
      rdata     = '0;
      sram_req  = '0;
      sram_addr = '0;
      sram_tag  = '0;
      miss_req  = 1'b0;
      miss_addr = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_i) begin
               sram_req  = '1;
               sram_addr = bus.index_i;
               gnt       = bus.sram_gnt_i;
               if (bus.sram_gnt_i) begin
                  index_d = bus.index_i;
                  state_d = S_TAG;
               end
            end
         end

         S_TAG: begin
            sram_tag = bus.tag_i;
            if (bus.kill_i) begin
               state_d = S_IDLE;
            end else if (!bus.tag_valid_i) begin
               state_d = S_REPLAY;
            end else if (|bus.hit_way_i) begin
               rvalid  = 1'b1;
               rdata   = hit_word;
               state_d = S_IDLE;
               // Pipelined issue: the next load's index phase overlaps this hit.
               if (bus.req_i) begin
                  sram_req  = '1;
                  sram_addr = bus.index_i;
                  gnt       = bus.sram_gnt_i;
                  if (bus.sram_gnt_i) begin
                     index_d = bus.index_i;
                     state_d = S_TAG;
                  end
               end
            end else begin
               tag_d   = bus.tag_i;
               state_d = S_MISS_REQ;
            end
         end

         S_REPLAY: begin
            if (bus.kill_i) begin
               state_d = S_IDLE;
            end else begin
               sram_req  = '1;
               sram_addr = index_q;
               if (bus.sram_gnt_i) state_d = S_TAG;
            end
         end

         S_MISS_REQ: begin
            miss_req  = 1'b1;
            miss_addr = {tag_q, index_q};
            if (bus.miss_gnt_i) begin
               // Once accepted the refill must be drained, so a kill is only remembered.
               killed_d = bus.kill_i;
               state_d  = S_MISS_WAIT;
            end else if (bus.kill_i) begin
               state_d = S_IDLE;
            end
         end

         S_MISS_WAIT: begin
            if (bus.miss_valid_i) begin
               rvalid   = refill_live;
               rdata    = refill_live ? bus.miss_rdata_i : '0;
               killed_d = 1'b0;
               state_d  = S_IDLE;
            end else if (bus.kill_i) begin
               killed_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.gnt_o       = gnt;
   assign bus.rvalid_o    = rvalid;
   assign bus.rdata_o     = rdata;
   assign bus.sram_req_o  = sram_req;
   assign bus.sram_addr_o = sram_addr;
   assign bus.sram_tag_o  = sram_tag;
   assign bus.miss_req_o  = miss_req;
   assign bus.miss_addr_o = miss_addr;

   a_single_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == S_TAG && bus.tag_valid_i && !bus.kill_i) |-> $onehot0(bus.hit_way_i));

endmodule

// File: tb/tb_dcache_load_ctrl.sv
// Scoreboarded random bench for dcache_load_ctrl: the driver plays core, SRAM
// stage and miss handler; expected load responses are queued and checked by a monitor.
module tb_dcache_load_ctrl;

   localparam int NW = 8;
   localparam int IW = 12;
   localparam int TW = 44;
   localparam int LW = 128;
   localparam int DW = 64;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   int   cyc_n = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_n <= cyc_n + 1;

   dcache_load_ctrl_if #(.SET_ASSOC(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
                         .LINE_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

   dcache_load_ctrl #(.SET_ASSOC(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
                      .LINE_WIDTH(LW), .DATA_WIDTH(DW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.master)
   );

   typedef struct {
      int          cyc;
      logic [63:0] data;
   } exp_t;

   typedef struct {
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
      bit            hit;
      int            way;
      int            gnt_dly;
      int            late;
      int            rep_dly;
      bit            kill_tag;
      int            mg_dly;
      int            mkill;     // 0 none, 1 kill without miss grant, 2 kill with miss grant
      int            mv_dly;
      int            mkill_at;  // MISS_WAIT cycle carrying a kill, -1 for none
      logic [63:0]   mdata;
      bit            use_fix;
      logic [63:0]   fix_hi;
   } txn_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [LW-1:0] lines [NW];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // Model: the line holds LW/64 words in ascending order; the byte offset picks one.
   function automatic logic [63:0] pick_word(input logic [LW-1:0] line, input logic [IW-1:0] idx);
      int wn;
      wn = (int'(idx) % (LW / 8)) / 8;
      return 64'(line >> (64 * wn));
   endfunction

   task automatic clear_inputs();
      bus.req_i        = 1'b0;
      bus.index_i      = '0;
      bus.tag_valid_i  = 1'b0;
      bus.tag_i        = '0;
      bus.kill_i       = 1'b0;
      bus.sram_gnt_i   = 1'b0;
      bus.hit_way_i    = '0;
      bus.line_i       = '0;
      bus.miss_gnt_i   = 1'b0;
      bus.miss_valid_i = 1'b0;
      bus.miss_rdata_i = '0;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      clear_inputs();
   endtask

   task automatic drive_lines();
      for (int w = 0; w < NW; w++) begin
         lines[w] = {$urandom, $urandom, $urandom, $urandom};
         bus.line_i[w*LW +: LW] = lines[w];
      end
   endtask

   task automatic chk_all_zero(input string tagname);
      chk({tagname, "_gnt"},       64'(bus.gnt_o), 0);
      chk({tagname, "_rvalid"},    64'(bus.rvalid_o), 0);
      chk({tagname, "_rdata"},     bus.rdata_o, 0);
      chk({tagname, "_sram_req"},  64'(bus.sram_req_o), 0);
      chk({tagname, "_sram_addr"}, 64'(bus.sram_addr_o), 0);
      chk({tagname, "_sram_tag"},  64'(bus.sram_tag_o), 0);
      chk({tagname, "_miss_req"},  64'(bus.miss_req_o), 0);
      chk({tagname, "_miss_addr"}, 64'(bus.miss_addr_o), 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_load(input txn_t t);
      bit killed;
      for (int g = 0; g <= t.gnt_dly; g++) begin
         step();
         bus.req_i      = 1'b1;
         bus.index_i    = t.idx;
         bus.sram_gnt_i = (g == t.gnt_dly);
         #2;
         chk("idle_gnt", 64'(bus.gnt_o), 64'(g == t.gnt_dly));
         chk("idle_sram_req", 64'(bus.sram_req_o), 64'({NW{1'b1}}));
         chk("idle_sram_addr", 64'(bus.sram_addr_o), 64'(t.idx));
      end
      for (int l = 0; l < t.late; l++) begin
         step();
         bus.tag_i = t.tag;
         #2;
         chk("late_sram_tag", 64'(bus.sram_tag_o), 64'(t.tag));
         for (int r = 0; r <= t.rep_dly; r++) begin
            step();
            bus.sram_gnt_i = (r == t.rep_dly);
            #2;
            chk("replay_sram_req", 64'(bus.sram_req_o), 64'({NW{1'b1}}));
            chk("replay_sram_addr", 64'(bus.sram_addr_o), 64'(t.idx));
            chk("replay_no_gnt", 64'(bus.gnt_o), 0);
         end
      end
      step();
      bus.tag_valid_i = 1'b1;
      bus.tag_i       = t.tag;
      drive_lines();
      if (t.use_fix) begin
         lines[t.way][LW-1 -: 64] = t.fix_hi;
         bus.line_i[t.way*LW +: LW] = lines[t.way];
      end
      if (t.kill_tag) begin
         bus.kill_i    = 1'b1;
         bus.hit_way_i = t.hit ? NW'(1 << t.way) : '0;
      end else if (t.hit) begin
         bus.hit_way_i = NW'(1 << t.way);
         exp_q.push_back('{cyc: cyc_n, data: pick_word(lines[t.way], t.idx)});
      end
      #2;
      chk("tag_sram_tag", 64'(bus.sram_tag_o), 64'(t.tag));
      chk("tag_no_gnt", 64'(bus.gnt_o), 0);
      if (t.kill_tag || t.hit) return;

      for (int m = 0; m <= t.mg_dly; m++) begin
         step();
         if (m == t.mg_dly) begin
            bus.miss_gnt_i = (t.mkill != 1);
            bus.kill_i     = (t.mkill != 0);
         end
         #2;
         chk("miss_req", 64'(bus.miss_req_o), 1);
         chk("miss_addr", 64'(bus.miss_addr_o), 64'({t.tag, t.idx}));
      end
      if (t.mkill == 1) return;
      killed = (t.mkill == 2);
      for (int v = 0; v <= t.mv_dly; v++) begin
         step();
         bus.miss_valid_i = (v == t.mv_dly);
         bus.miss_rdata_i = (v == t.mv_dly) ? t.mdata : {$urandom, $urandom};
         if (v == t.mkill_at) begin
            bus.kill_i = 1'b1;
            killed     = 1'b1;
         end
         if (bus.miss_valid_i && !killed)
            exp_q.push_back('{cyc: cyc_n, data: t.mdata});
         #2;
         chk("wait_no_miss_req", 64'(bus.miss_req_o), 0);
      end
   endtask

   task automatic run_burst(input int n);
      logic [IW-1:0] idx [8];
      int            way [8];
      for (int i = 0; i < n; i++) begin
         idx[i] = IW'($urandom);
         way[i] = int'($urandom_range(0, NW - 1));
      end
      step();
      bus.req_i      = 1'b1;
      bus.index_i    = idx[0];
      bus.sram_gnt_i = 1'b1;
      #2;
      chk("burst_gnt0", 64'(bus.gnt_o), 1);
      for (int i = 0; i < n; i++) begin
         step();
         bus.tag_valid_i = 1'b1;
         bus.tag_i       = {$urandom, $urandom};
         drive_lines();
         bus.hit_way_i = NW'(1 << way[i]);
         exp_q.push_back('{cyc: cyc_n, data: pick_word(lines[way[i]], idx[i])});
         if (i < n - 1) begin
            bus.req_i      = 1'b1;
            bus.index_i    = idx[i+1];
            bus.sram_gnt_i = 1'b1;
         end
         #2;
         chk("burst_gnt", 64'(bus.gnt_o), 64'(i < n - 1));
      end
   endtask

   function automatic txn_t base_txn(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input bit hit);
      txn_t t;
      t.idx = idx;  t.tag = tag;  t.hit = hit;  t.way = 0;
      t.gnt_dly = 0;  t.late = 0;  t.rep_dly = 0;  t.kill_tag = 1'b0;
      t.mg_dly = 0;  t.mkill = 0;  t.mv_dly = 0;  t.mkill_at = -1;
      t.mdata = {$urandom, $urandom};  t.use_fix = 1'b0;  t.fix_hi = '0;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      int   k;
      t = base_txn(IW'($urandom), {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
      t.way      = int'($urandom_range(0, NW - 1));
      t.gnt_dly  = int'($urandom_range(0, 2));
      t.late     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      t.rep_dly  = int'($urandom_range(0, 2));
      t.kill_tag = ($urandom_range(0, 9) == 0);
      t.mg_dly   = int'($urandom_range(0, 3));
      k          = int'($urandom_range(0, 7));
      t.mkill    = (k < 2) ? k + 1 : 0;
      t.mv_dly   = int'($urandom_range(0, 5));
      t.mkill_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, t.mv_dly)) : -1;
      return t;
   endfunction

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (bus.rvalid_o) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rvalid_unexpected: got rdata %0h expected no response (cycle %0d)",
                        bus.rdata_o, cyc_n);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rvalid_cycle", 64'(cyc_n), 64'(mon_e.cyc));
               chk("rdata", bus.rdata_o, mon_e.data);
            end
         end else begin
            chk("rdata_zero_when_idle", bus.rdata_o, 0);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc_n) begin
               mon_e = exp_q.pop_front();
               chk("rvalid_missing", 64'(bus.rvalid_o), 1);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      txn_t t;
      clear_inputs();
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #3;
      chk_all_zero("in_reset");
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      step();
      #2;
      chk_all_zero("post_reset");

      t = base_txn(12'h048, 44'h5A5, 1'b1);
      t.way = 3;  t.use_fix = 1'b1;  t.fix_hi = 64'hDEAD_BEEF_0000_0001;
      run_load(t);

      run_burst(4);

      t = base_txn(12'h100, 44'h123, 1'b0);
      t.mg_dly = 2;  t.mv_dly = 5;  t.mdata = 64'hCAFE;
      run_load(t);
      run_load(base_txn(12'h018, 44'h77, 1'b1));

      t = base_txn(12'h2A8, 44'hABC, 1'b1);
      t.way = 5;  t.late = 1;  t.rep_dly = 1;
      run_load(t);

      t = base_txn(12'h300, 44'h9, 1'b0);
      t.mg_dly = 1;  t.mv_dly = 4;  t.mkill_at = 2;
      run_load(t);
      t = base_txn(12'h0F0, 44'h1, 1'b1);
      t.way = 6;  t.kill_tag = 1'b1;
      run_load(t);
      run_load(base_txn(12'h008, 44'h2, 1'b1));

      t = base_txn(12'h040, 44'h3, 1'b0);
      t.mv_dly = 2;  t.mkill_at = 2;
      run_load(t);
      t = base_txn(12'h050, 44'h4, 1'b0);
      t.mkill = 1;
      run_load(t);
      t = base_txn(12'h060, 44'h5, 1'b0);
      t.mkill = 2;  t.mv_dly = 1;
      run_load(t);

      // Reset while a refill is outstanding.
      step();
      bus.req_i = 1'b1;  bus.index_i = 12'h210;  bus.sram_gnt_i = 1'b1;
      step();
      bus.tag_valid_i = 1'b1;  bus.tag_i = 44'h55;
      step();
      bus.miss_gnt_i = 1'b1;
      step();
      rst_ni = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      step();
      rst_ni = 1'b1;
      step();
      #2;
      chk_all_zero("after_mid_reset");
      run_load(base_txn(12'h218, 44'h56, 1'b1));

      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 9) == 0) run_burst(int'($urandom_range(2, 8)));
         else run_load(rand_txn());
         if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
      end

      idle_cycles(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
